// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x3 matrix keypad front end.
//   - KEY_* : 4-bit key codes (digits 0-9, star, hash, plus the
//             frame-level NONE / MULTI results)
//   - state_t : debounce FSM states
//   - code_to_onehot : digit code -> 10-bit K pattern (K[9-d] marks digit d)
//   - pos_to_code : (row, column) position on the keypad -> key code
package keypad_pkg;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] KEY_NONE  = 4'd12;
    localparam logic [3:0] KEY_MULTI = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        HELD
    } state_t;

    // Non-digit codes produce an all-zero pattern.
    function automatic logic [9:0] code_to_onehot(input logic [3:0] code);
        logic [9:0] k;
        k = '0;
        if (code <= KEY_9) begin
            k = 10'b10_0000_0000 >> code;
        end
        return k;
    endfunction

    // Row-major position index r*3+c walks 1..9, then '*', '0', '#'.
    function automatic logic [3:0] pos_to_code(input logic [1:0] row,
                                               input logic [1:0] col);
        logic [3:0] idx;
        logic [3:0] code;
        idx = ({2'b00, row} * 4'd3) + {2'b00, col};
        case (idx)
            4'd9:    code = KEY_STAR;
            4'd10:   code = KEY_0;
            4'd11:   code = KEY_HASH;
            default: code = idx + 4'd1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_col_sync.sv
// col_sync
// Two-flop synchroniser for a bus of independent asynchronous inputs.
// Both stages reset to all-ones so a pulled-up (idle) input reads as idle
// straight out of reset.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bus
//   q     : synchronised output bus (2 clocks of latency)
module col_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4-row x 3-column matrix keypad, resolves each full scan frame to
// NONE / single key / MULTI, debounces the frame results and emits exactly
// one single-clock event per accepted press.
//   CLK   : clock
//   RST_N : asynchronous active-low reset
//   COL_N : keypad columns, active-low, asynchronous
//   ROW_N : row drive, active-low, one-cold
//   K     : one-hot digit pulse, K[9-d] marks digit d
//   del   : delete pulse for the '#' key
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] COL_N,
    output logic [3:0] ROW_N,
    output logic [9:0] K,
    output logic       del
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);

    logic [2:0]        col_n_s;
    logic [2:0]        closed;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [3:0]        acc_code_q, acc_code_d;
    state_t            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        k_q, k_d;
    logic              del_q, del_d;

    logic              slot_last;
    logic              frame_end;
    logic [1:0]        row_hits;
    logic [1:0]        first_col;
    logic [2:0]        hit_sum;
    logic [1:0]        merged_cnt;
    logic [3:0]        merged_code;
    logic [3:0]        frame_code;
    logic              frame_single;
    logic [CNT_W-1:0]  cnt_inc;
    logic              emit;
    logic [3:0]        emit_code;

    col_sync #(
        .WIDTH(3)
    ) u_col_sync (
        .clk  (CLK),
        .rst_n(RST_N),
        .d    (COL_N),
        .q    (col_n_s)
    );

    assign closed = ~col_n_s;

    // Slot/row timebase plus per-frame closure accumulation. Each row's
    // columns are folded in on the last clock of its slot; the closure count
    // saturates at 2 because anything beyond one closure is simply MULTI.
    // Only the first closure's code is kept, since it is only used when the
    // frame turns out to contain exactly one.
    always_comb begin
        slot_last = (slot_q == SLOT_LAST);
        frame_end = slot_last && (row_q == 2'd3);
        slot_d    = slot_last ? '0 : slot_q + 1'b1;
        row_d     = slot_last ? row_q + 2'd1 : row_q;

        row_hits  = 2'(closed[0]) + 2'(closed[1]) + 2'(closed[2]);
        first_col = closed[0] ? 2'd0 : (closed[1] ? 2'd1 : 2'd2);

        hit_sum     = {1'b0, acc_cnt_q} + {1'b0, row_hits};
        merged_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_code = (acc_cnt_q == 2'd0) ? pos_to_code(row_q, first_col) : acc_code_q;

        case (merged_cnt)
            2'd0:    frame_code = KEY_NONE;
            2'd1:    frame_code = merged_code;
            default: frame_code = KEY_MULTI;
        endcase
        frame_single = (frame_code <= KEY_HASH);

        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (slot_last) begin
            acc_cnt_d  = merged_cnt;
            acc_code_d = merged_code;
        end
    end

    // Debounce FSM, advanced once per frame. The counter counts matching
    // frames in CAND and empty frames in HELD, so it is cleared on entry to
    // HELD to give the full release window.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = cand_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_code;
                        if (DEBOUNCE == 1) begin
                            emit      = 1'b1;
                            emit_code = frame_code;
                            cnt_d     = '0;
                            state_d   = HELD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = CAND;
                        end
                    end
                end
                CAND: begin
                    if (frame_code == cand_q) begin
                        if (cnt_inc == CNT_MAX) begin
                            emit    = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frame_code == KEY_NONE) begin
                        if (cnt_inc == CNT_MAX) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        // '*' yields neither a digit pattern nor del.
        k_d   = emit ? code_to_onehot(emit_code) : '0;
        del_d = emit && (emit_code == KEY_HASH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q     <= '0;
            row_q      <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
            state_q    <= IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            del_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            row_q      <= row_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            del_q      <= del_d;
        end
    end

    assign ROW_N = ~(4'b0001 << row_q);
    assign K     = k_q;
    assign del   = del_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Randomised and directed stimulus for keypad_scan with SCAN_DIV=4,
// DEBOUNCE=3 (16-clock frames). A keypad model turns a 12-bit "keys held"
// mask into column levels from the live row drive. A frame-level reference
// model predicts each event and its clock; a monitor compares every pulse
// the DUT presents against the queue of predictions.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    typedef struct {
        logic [9:0] k;
        logic       d;
        int         cyc;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic [2:0] COL_N;
    logic [3:0] ROW_N;
    logic [9:0] K;
    logic       del;

    logic [11:0] key_mask;
    logic        col_force;
    logic [2:0]  col_rand;
    logic [2:0]  col_model;

    exp_t  exp_q[$];
    int    errors;
    int    checks;
    int    cyc;
    int    fidx;
    string key_chars = "123456789*0#";

    // Reference model state: length of the current run of one identical key,
    // whether a press has been accepted and not yet released, and the length
    // of the current run of empty frames while held.
    int m_run_code;
    int m_run_len;
    bit m_held;
    int m_empty;

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .COL_N(COL_N),
        .ROW_N(ROW_N),
        .K    (K),
        .del  (del)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Passive keypad: a held key pulls its column low while its row is driven.
    always_comb begin
        col_model = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!ROW_N[r] && key_mask[r*3+c]) begin
                    col_model[c] = 1'b0;
                end
            end
        end
        COL_N = col_force ? col_rand : col_model;
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [11:0] keyMask(input byte ch);
        logic [11:0] m;
        m = '0;
        for (int i = 0; i < 12; i++) begin
            if (key_chars[i] == ch) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic checkValue(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        m_run_code = -1;
        m_run_len  = 0;
        m_held     = 1'b0;
        m_empty    = 0;
        fidx       = 0;
        exp_q.delete();
    endtask

    // Feeds one frame's worth of held keys to the reference model.
    task automatic modelFrame(input logic [11:0] mask);
        int   n;
        int   obs;
        byte  ch;
        exp_t e;
        n   = $countones(mask);
        obs = -1;
        for (int i = 0; i < 12; i++) if (mask[i]) obs = i;
        if (!m_held) begin
            if (n == 1 && m_run_len == 0) begin
                m_run_code = obs;
                m_run_len  = 1;
            end else if (n == 1 && obs == m_run_code) begin
                m_run_len++;
            end else begin
                m_run_len = 0;
            end
            if (m_run_len == DEBOUNCE) begin
                ch    = key_chars[m_run_code];
                e.k   = '0;
                e.d   = 1'b0;
                e.cyc = FRAME * (fidx + 1);
                if (ch >= "0" && ch <= "9") begin
                    e.k[9 - (int'(ch) - 48)] = 1'b1;
                    exp_q.push_back(e);
                end else if (ch == "#") begin
                    e.d = 1'b1;
                    exp_q.push_back(e);
                end
                m_held    = 1'b1;
                m_empty   = 0;
                m_run_len = 0;
            end
        end else begin
            if (n == 0) m_empty++;
            else        m_empty = 0;
            if (m_empty == DEBOUNCE) m_held = 1'b0;
        end
        fidx++;
    endtask

    // Holds the given key set for a number of whole frames. Called at the
    // falling edge inside the first clock of a frame.
    task automatic applyStimulus(input logic [11:0] mask, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            key_mask = mask;
            modelFrame(mask);
            repeat (FRAME) @(negedge CLK);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pulse: K=%b del=%b at cycle %0d, expected no pulse", K, del, cyc);
        end else begin
            e = exp_q.pop_front();
            if (K !== e.k || del !== e.d || cyc != e.cyc) begin
                errors++;
                $display("[TB] FAIL pulse: got K=%b del=%b cycle=%0d, expected K=%b del=%b cycle=%0d",
                         K, del, cyc, e.k, e.d, e.cyc);
            end
        end
    endtask

    // Monitor: every clock that shows a pulse must match the next prediction.
    always @(negedge CLK) begin
        if (RST_N && (K != '0 || del)) checkOutput();
    end

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, "_row_n"}, int'(ROW_N), 32'hE);
        checkValue({tag, "_k"}, int'(K), 0);
        checkValue({tag, "_del"}, int'(del), 0);
    endtask

    // Resets mid-run at the start of a frame; any pending prediction is dropped.
    task automatic pulseReset();
        RST_N = 1'b0;
        #1;
        modelReset();
        checkResetOutputs("midreset");
        @(negedge CLK);
        checkResetOutputs("midreset_hold");
        RST_N = 1'b1;
    endtask

    initial begin
        logic [11:0] m;
        logic [3:0]  exp_row;
        int          sel;

        errors    = 0;
        checks    = 0;
        key_mask  = '0;
        col_force = 1'b1;
        col_rand  = 3'($urandom);
        RST_N     = 1'b0;
        modelReset();

        // Reset with random column levels.
        repeat (3) begin
            @(negedge CLK);
            col_rand = 3'($urandom_range(0, 7));
            checkResetOutputs("reset");
        end
        RST_N     = 1'b1;
        col_force = 1'b0;

        // Row drive steps through the four rows every SCAN_DIV clocks.
        for (int r = 0; r < 4; r++) begin
            exp_row = ~(4'b0001 << r);
            checkValue("row_step", int'(ROW_N), int'(exp_row));
            repeat (SCAN_DIV) @(negedge CLK);
        end
        modelFrame('0);

        // Clean digit '5'.
        applyStimulus(keyMask("5"), 10);
        applyStimulus('0, 3);

        // Delete key, then the reserved star key.
        applyStimulus(keyMask("#"), 5);
        applyStimulus('0, 3);
        applyStimulus(keyMask("*"), 5);
        applyStimulus('0, 3);

        // Bounce on '7'.
        applyStimulus(keyMask("7"), 2);
        applyStimulus('0, 1);
        applyStimulus(keyMask("7"), 2);
        applyStimulus('0, 3);

        // Chords.
        applyStimulus(keyMask("1") | keyMask("2"), 4);
        applyStimulus('0, 3);
        applyStimulus(keyMask("0"), 4);
        applyStimulus(keyMask("0") | keyMask("8"), 3);
        applyStimulus('0, 3);
        applyStimulus(keyMask("8"), 4);
        applyStimulus('0, 3);

        // Reset in the middle of debouncing '9', key kept held across it.
        applyStimulus(keyMask("9"), 2);
        pulseReset();
        applyStimulus(keyMask("9"), 4);
        applyStimulus('0, 3);

        // Random key activity, frame-aligned.
        m = '0;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55) begin
                m = m;
            end else if (sel < 70) begin
                m = '0;
            end else if (sel < 92) begin
                m = 12'b1 << $urandom_range(0, 11);
            end else begin
                m = (12'b1 << $urandom_range(0, 11)) | (12'b1 << $urandom_range(0, 11));
            end
            applyStimulus(m, 1);
        end
        applyStimulus('0, 4);

        checkValue("pending_pulses", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
